// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction, waits for its data response,
// extends load data, and drops responses that belong to flushed loads.
module mem_stage #(
  parameter int DISCARD_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic [31:0] es_result,
  input  logic [4:0]  es_dest,
  input  logic        es_gr_we,
  input  logic [2:0]  es_mem_op,
  input  logic        es_req_sent,
  input  logic        es_ex,
  input  logic [5:0]  es_ecode,
  input  logic        es_ertn,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  input  logic        flush,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic [31:0] ms_final_result,
  output logic [4:0]  ms_dest,
  output logic        ms_gr_we,
  output logic        ms_ex,
  output logic [5:0]  ms_ecode,
  output logic [31:0] ms_badv,
  output logic        ms_fwd_valid,
  output logic        ms_fwd_stall,
  output logic        ms_ex_or_ertn
);

  localparam logic [DISCARD_W-1:0] DMAX = '1;

  logic                 valid_q;
  logic [31:0]          pc_q;
  logic [31:0]          result_q;
  logic [4:0]           dest_q;
  logic                 gr_we_q;
  logic [2:0]           mem_op_q;
  logic                 req_sent_q;
  logic                 ex_q;
  logic [5:0]           ecode_q;
  logic                 ertn_q;
  logic [31:0]          buf_q;
  logic                 buf_valid_q;
  logic [DISCARD_W-1:0] discard_q;
  logic [DISCARD_W-1:0] discard_d;

  logic wait_w;
  logic data_hit;
  logic ready_go;
  logic accept;
  logic advance;
  logic is_load;
  logic inc;
  logic dec;

  assign wait_w   = valid_q && req_sent_q && !ex_q;
  assign data_hit = data_ok && (discard_q == '0);
  assign ready_go = !wait_w || data_hit || buf_valid_q;
  assign advance  = valid_q && ready_go && ws_allowin;
  assign accept   = es_to_ms_valid && ms_allowin && !flush;
  assign is_load  = (mem_op_q != 3'b000) && (mem_op_q != 3'b110)
                 && (mem_op_q != 3'b111);

  assign ms_allowin     = !valid_q || (ready_go && ws_allowin);
  assign ms_to_ws_valid = valid_q && ready_go;
  assign ms_pc          = pc_q;
  assign ms_dest        = dest_q;
  assign ms_gr_we       = valid_q && gr_we_q && !ex_q;
  assign ms_fwd_valid   = valid_q && gr_we_q && !ex_q;
  assign ms_ex          = ex_q;
  assign ms_ecode       = ecode_q;
  assign ms_badv        = result_q;
  assign ms_fwd_stall   = valid_q && is_load && !ready_go;
  assign ms_ex_or_ertn  = valid_q && (ex_q || ertn_q);

  // A flushed load still owes us a response; remember to drop it.
  assign inc = flush && wait_w && !data_hit && !buf_valid_q;
  assign dec = data_ok && (discard_q != '0);

  always_comb begin
    discard_d = discard_q;
    if (inc && !dec && discard_q != DMAX) discard_d = discard_q + 1'b1;
    else if (dec && !inc) discard_d = discard_q - 1'b1;
  end

  logic [31:0] raw;
  logic [7:0]  byte_w;
  logic [15:0] half_w;

  assign raw    = buf_valid_q ? buf_q : rdata;
  assign half_w = result_q[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    byte_w = raw[7:0];
    case (result_q[1:0])
      2'd1:    byte_w = raw[15:8];
      2'd2:    byte_w = raw[23:16];
      2'd3:    byte_w = raw[31:24];
      default: byte_w = raw[7:0];
    endcase
  end

  always_comb begin
    ms_final_result = result_q;
    case (mem_op_q)
      3'b001: ms_final_result = raw;
      3'b010: ms_final_result = {{24{byte_w[7]}}, byte_w};
      3'b011: ms_final_result = {24'd0, byte_w};
      3'b100: ms_final_result = {{16{half_w[15]}}, half_w};
      3'b101: ms_final_result = {16'd0, half_w};
      default: ms_final_result = result_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      result_q    <= '0;
      dest_q      <= '0;
      gr_we_q     <= 1'b0;
      mem_op_q    <= '0;
      req_sent_q  <= 1'b0;
      ex_q        <= 1'b0;
      ecode_q     <= '0;
      ertn_q      <= 1'b0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      discard_q   <= '0;
    end else begin
      discard_q <= discard_d;
      if (flush) valid_q <= 1'b0;
      else if (accept) valid_q <= 1'b1;
      else if (advance) valid_q <= 1'b0;
      if (accept) begin
        pc_q       <= es_pc;
        result_q   <= es_result;
        dest_q     <= es_dest;
        gr_we_q    <= es_gr_we;
        mem_op_q   <= es_mem_op;
        req_sent_q <= es_req_sent;
        ex_q       <= es_ex;
        ecode_q    <= es_ecode;
        ertn_q     <= es_ertn;
      end
      // Park the response when writeback is busy; extra strobes are ignored.
      if (flush || advance) begin
        buf_valid_q <= 1'b0;
      end else if (wait_w && data_hit && !ws_allowin && !buf_valid_q) begin
        buf_q       <= rdata;
        buf_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the writeback stage.
- Holds one instruction and waits for the data-memory response when its request was accepted upstream.
- Sign- or zero-extends load data by byte lane and passes exceptions through.
- Discards responses belonging to flushed instructions, drives forwarding/stall info to decode, and tells execute when to suppress new stores.

Parameters:
- DISCARD_W, 2, width of the counter of in-flight responses to be dropped after a flush (at most 2^DISCARD_W-1 outstanding).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- es_to_ms_valid  in  1  execute presents an instruction
- ms_allowin  out  1  stage can accept
- es_pc  in  32  instruction PC
- es_result  in  32  ALU result or memory address
- es_dest  in  5  destination register
- es_gr_we  in  1  register write enable
- es_mem_op  in  3  000 none, 001 ld.w, 010 ld.b, 011 ld.bu, 100 ld.h, 101 ld.hu, 110 store
- es_req_sent  in  1  memory accepted this instruction's request (addr_ok seen)
- es_ex  in  1  exception already raised upstream
- es_ecode  in  6  exception code
- es_ertn  in  1  instruction is ertn
- data_ok  in  1  memory response strobe
- rdata  in  32  memory read data
- flush  in  1  writeback exception/ertn flush
- ws_allowin  in  1  writeback can accept
- ms_to_ws_valid  out  1  valid to writeback
- ms_pc  out  32  PC
- ms_final_result  out  32  load data or passed result
- ms_dest  out  5  destination register
- ms_gr_we  out  1  register write enable, qualified by valid and !ms_ex
- ms_ex  out  1  exception
- ms_ecode  out  6  exception code
- ms_badv  out  32  es_result latched, for ALE/TLB faults
- ms_fwd_valid  out  1  valid && gr_we && !ex
- ms_fwd_stall  out  1  load result not yet available; decode must stall
- ms_ex_or_ertn  out  1  valid && (ex || ertn); execute suppresses write strobes

Behaviour:
- Reset: ms_valid=0, payload registers=0, discard_cnt=0, buf_valid=0.
  - Consequently every output is 0, except ms_allowin=1.
- Accept: when es_to_ms_valid && ms_allowin && !flush, latch all inputs and set ms_valid=1 next cycle.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- Wait condition: wait = ms_valid && es_req_sent_r && !ms_ex_r.
  - ms_ready_go = !wait || data_hit || buf_valid.
  - data_hit = data_ok && discard_cnt==0.
- Response buffer: if data_hit && !ws_allowin, store rdata in buf and set buf_valid=1.
  - buf_valid clears on advance to writeback or on flush.
  - A second data_ok while buf_valid=1 is a protocol error: ignore it and assert it in the bench.
- Latency: a non-memory instruction passes in 1 cycle. A load completes in the cycle data_ok arrives (combinational from rdata), or later from buf.
- Load extension, with lane = es_result_r[1:0]:
  - ld.b / ld.bu: byte rdata[8*lane+7 : 8*lane], sign- or zero-extended.
  - ld.h / ld.hu: half at lane[1] (lane[1]=0 → rdata[15:0], 1 → rdata[31:16]), sign- or zero-extended.
  - ld.w: full word.
  - Store or none: ms_final_result = es_result_r.
- ms_fwd_stall = ms_valid && load && !ms_ready_go.
- Flush: ms_valid←0 and buf_valid←0 next cycle. If the flushed instruction was waiting with no response yet (wait && !data_hit && !buf_valid), discard_cnt←discard_cnt+1. Incoming es_to_ms_valid is ignored that cycle.
- Discard: while discard_cnt>0, each data_ok decrements the counter and is not consumed.
  - data_ok while discard_cnt>0 in the same cycle as a flush-increment nets to no change.
  - The counter saturates at max; reaching max is a bench assertion failure.
- Exception instructions (es_ex=1) never wait, even if es_req_sent=1; execute never sends requests for them.
- Reset mid-operation clears everything. Responses already in flight at reset are the interconnect's responsibility.

Test Plan:
- add result 0x1234 with ws_allowin=1 → ms_to_ws_valid one cycle after accept, ms_final_result=0x1234, ms_fwd_stall=0.
- ld.b addr 0x...03, data_ok 2 cycles later with rdata=0x80FF_0000 → stall high 2 cycles, then result 0xFFFFFF80; ld.bu same case → 0x00000080.
- ld.hu addr 0x...02, rdata=0xBEEF_1111, data_ok while ws_allowin=0 → buf_valid=1; ws_allowin=1 two cycles later → result 0x0000BEEF, no re-wait.
- Load waiting, flush asserted → discard_cnt=1. Next load accepted, then first data_ok with rdata 0xDEAD → dropped; second data_ok 0x5 → result 0x5, discard_cnt=0.
- es_ex=1, ecode 0x09, es_req_sent=1, es_result 0x1001 → passes in 1 cycle, ms_ex=1, ms_badv=0x1001, ms_gr_we=0, ms_ex_or_ertn=1.
- ertn accepted → ms_ex_or_ertn=1 while valid. Back-to-back loads with immediate data_ok and ws_allowin=1 → one instruction per cycle throughput.
